// File: rtl/controller_pio_pkg.sv
// rtl/controller_pio_pkg.sv - shared encodings and register offsets for the controller PIO blocks
//
// Contents:
//   edge_type_e  : per-bit capture condition (rising, falling, any)
//   ADDR_*       : register word offsets on the slave bus
//   edge_detect  : edge mask from current and previous filtered levels

package controller_pio_pkg;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RSVD    = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  // Worked at full bus width so callers of any WIDTH can share it.
  function automatic logic [31:0] edge_detect(
    input logic [31:0] cur,
    input logic [31:0] prev,
    input edge_type_e  kind
  );
    logic [31:0] rise;
    logic [31:0] fall;
    rise = cur & ~prev;
    fall = ~cur & prev;
    case (kind)
      EDGE_RISING:  edge_detect = rise;
      EDGE_FALLING: edge_detect = fall;
      default:      edge_detect = rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/controller_pio_debounce.sv
// rtl/controller_pio_debounce.sv - one-bit synchronizer and debounce filter
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   din      in   asynchronous external input bit
//   deb      out  filtered level (IDLE_BIT after reset)
//
// A new level at the synchronizer output must persist DEBOUNCE_CYCLES clocks
// before it is accepted; DEBOUNCE_CYCLES = 0 passes the synchronized bit through.

module controller_pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 0,
  parameter logic IDLE_BIT        = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb
);

  logic s1;
  logic s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= IDLE_BIT;
      s2 <= IDLE_BIT;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign deb = s2;
  end else begin : g_filter
    // A single-cycle filter still needs a one-bit counter to exist.
    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          deb_q;

    // Any return to the accepted level clears the count, so only an
    // uninterrupted run of the new level gets through.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        deb_q <= IDLE_BIT;
        cnt   <= '0;
      end else if (s2 == deb_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb_q <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end

    assign deb = deb_q;
  end

endmodule

// File: rtl/controller_keys_edge_in.sv
// rtl/controller_keys_edge_in.sv - input PIO for keys/switches with edge capture and interrupt
//
// Ports:
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   address     in   register word offset (0 DATA, 1 reads 0, 2 IRQMASK, 3 EDGECAP)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data, bits above WIDTH ignored
//   readdata    out  combinational read data, zero-extended above WIDTH
//   in_port     in   asynchronous external inputs
//   irq         out  level interrupt, |(EDGECAP & IRQMASK)

module controller_keys_edge_in
  import controller_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 0,
  parameter edge_type_e       EDGE_TYPE       = EDGE_RISING,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] det;
  logic [WIDTH-1:0] clr;
  logic             wr_en;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    controller_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_BIT        (IDLE_LEVEL[i])
    ) u_debounce (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (in_port[i]),
      .deb     (deb[i])
    );
  end

  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  assign wr_en = chipselect && !write_n;
  assign det   = WIDTH'(edge_detect(32'(deb), 32'(deb_d), EDGE_TYPE));
  assign clr   = (wr_en && address == ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;

  // deb_d resets to the idle level so reset release never looks like an edge.
  // Clear is applied before set, so a same-cycle edge keeps its bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d   <= IDLE_LEVEL;
      edgecap <= '0;
      irqmask <= '0;
    end else begin
      deb_d   <= deb;
      edgecap <= (edgecap & ~clr) | det;
      if (wr_en && address == ADDR_IRQMASK) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata = 32'(deb);
      ADDR_IRQMASK: readdata = 32'(irqmask);
      ADDR_EDGECAP: readdata = 32'(edgecap);
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap & irqmask);

endmodule

// File: tb/tb_controller_keys_edge_in.sv
// tb/tb_controller_keys_edge_in.sv - self-checking bench for controller_keys_edge_in

module tb_controller_keys_edge_in;
  import controller_pio_pkg::*;

  localparam int W = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = 32'd0;
  logic [W-1:0]  pins_a = 4'hF;
  logic [W-1:0]  pins_b = 4'h0;
  logic [31:0]   rd_a;
  logic [31:0]   rd_b;
  logic          irq_a;
  logic          irq_b;

  int total = 0;
  int bad = 0;
  logic chk_on = 1'b0;
  logic [1:0] rot = 2'd0;

  always #10 clk = ~clk;

  // Instance A: debounced, rising-edge capture, pulled-up pins.
  controller_keys_edge_in #(
    .WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(EDGE_RISING), .IDLE_LEVEL(4'hF)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a), .in_port(pins_a), .irq(irq_a)
  );

  // Instance B: filter bypassed, any-edge capture, pulled-down pins.
  controller_keys_edge_in #(
    .WIDTH(W), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(EDGE_ANY), .IDLE_LEVEL(4'h0)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b), .in_port(pins_b), .irq(irq_b)
  );

  function automatic logic [W-1:0] idle_of(int n);
    return (n == 0) ? 4'hF : 4'h0;
  endfunction

  function automatic int dcyc_of(int n);
    return (n == 0) ? 4 : 0;
  endfunction

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_s1 [2];
  logic [W-1:0] m_s2 [2];
  logic [W-1:0] m_deb [2];
  logic [W-1:0] m_prev [2];
  logic [W-1:0] m_cap [2];
  logic [W-1:0] m_mask;
  int           m_run [2][W];

  always @(posedge clk or negedge reset_n) begin : model
    logic [W-1:0] pins;
    logic [W-1:0] nd;
    logic [W-1:0] ch;
    logic [W-1:0] det;
    logic [W-1:0] clr;
    if (!reset_n) begin
      for (int n = 0; n < 2; n++) begin
        m_s1[n]   <= idle_of(n);
        m_s2[n]   <= idle_of(n);
        m_deb[n]  <= idle_of(n);
        m_prev[n] <= idle_of(n);
        m_cap[n]  <= '0;
        for (int b = 0; b < W; b++) m_run[n][b] <= 0;
      end
      m_mask <= '0;
    end else begin
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int n = 0; n < 2; n++) begin
        pins = (n == 0) ? pins_a : pins_b;
        nd = m_deb[n];
        for (int b = 0; b < W; b++) begin
          if (dcyc_of(n) == 0) begin
            nd[b] = m_s1[n][b];
          end else if (m_s2[n][b] == m_deb[n][b]) begin
            m_run[n][b] <= 0;
          end else if (m_run[n][b] + 1 == dcyc_of(n)) begin
            nd[b] = m_s2[n][b];
            m_run[n][b] <= 0;
          end else begin
            m_run[n][b] <= m_run[n][b] + 1;
          end
        end
        ch  = m_deb[n] ^ m_prev[n];
        det = (n == 1) ? ch : (ch & m_deb[n]);
        m_s1[n]   <= pins;
        m_s2[n]   <= m_s1[n];
        m_deb[n]  <= nd;
        m_prev[n] <= m_deb[n];
        m_cap[n]  <= (m_cap[n] & ~clr) | det;
      end
      if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[W-1:0];
    end
  end

  function automatic logic [31:0] exp_rd(int n, logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_deb[n]};
      2'd1:    return 32'd0;
      2'd2:    return {28'd0, m_mask};
      default: return {28'd0, m_cap[n]};
    endcase
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_rd_a", rd_a, exp_rd(0, address));
      chk("model_rd_b", rd_b, exp_rd(1, address));
      chk("model_irq_a", 32'(irq_a), 32'(|(m_cap[0] & m_mask)));
      chk("model_irq_b", 32'(irq_b), 32'(|(m_cap[1] & m_mask)));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      address = rot;
      rot = rot + 2'd1;
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a;
    writedata = d;
    chipselect = 1'b1;
    write_n = 1'b0;
    cyc();
    chipselect = 1'b0;
    write_n = 1'b1;
    writedata = 32'd0;
  endtask

  task automatic rd(string name, int inst, logic [1:0] a, logic [31:0] exp);
    address = a;
    #1;
    chk(name, (inst == 0) ? rd_a : rd_b, exp);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) cyc();
    chk_on = 1'b1;
    rd("reset_data_a", 0, 2'd0, 32'hF);
    rd("reset_mask_a", 0, 2'd2, 32'h0);
    rd("reset_cap_a", 0, 2'd3, 32'h0);
    rd("reset_data_b", 1, 2'd0, 32'h0);
    chk("reset_irq_a", 32'(irq_a), 32'd0);

    reset_n = 1'b1;
    tick(20);
    rd("idle_nocap_a", 0, 2'd3, 32'h0);
    rd("idle_nocap_b", 1, 2'd3, 32'h0);

    // Latency: bit0 0->1 with 4-cycle filter, masked in.
    wr(2'd2, 32'h1);
    pins_a[0] = 1'b0;
    tick(10);
    rd("lat_pre_data", 0, 2'd0, 32'hE);
    rd("lat_pre_cap", 0, 2'd3, 32'h0);
    pins_a[0] = 1'b1;
    cyc();
    repeat (4) cyc();
    rd("lat_k4_data", 0, 2'd0, 32'hE);
    cyc();
    rd("lat_k5_data", 0, 2'd0, 32'hF);
    rd("lat_k5_cap", 0, 2'd3, 32'h0);
    cyc();
    rd("lat_k6_cap", 0, 2'd3, 32'h1);
    chk("lat_k6_irq", 32'(irq_a), 32'd1);
    wr(2'd3, 32'h1);
    rd("w1c_cap", 0, 2'd3, 32'h0);
    chk("w1c_irq", 32'(irq_a), 32'd0);

    // Glitch rejection on bit1.
    pins_a[1] = 1'b0;
    tick(10);
    rd("gl_pre_data", 0, 2'd0, 32'hD);
    pins_a[1] = 1'b1;
    repeat (3) cyc();
    pins_a[1] = 1'b0;
    tick(12);
    rd("gl3_data", 0, 2'd0, 32'hD);
    rd("gl3_cap", 0, 2'd3, 32'h0);
    pins_a[1] = 1'b1;
    repeat (4) cyc();
    pins_a[1] = 1'b0;
    tick(12);
    rd("gl4_cap", 0, 2'd3, 32'h2);
    chk("gl4_irq", 32'(irq_a), 32'd0);

    // W1C collision on bit0.
    pins_a[0] = 1'b0;
    tick(10);
    pins_a[0] = 1'b1;
    tick(10);
    rd("col_pre_cap", 0, 2'd3, 32'h3);
    pins_a[0] = 1'b0;
    tick(10);
    pins_a[0] = 1'b1;
    cyc();
    repeat (5) cyc();
    wr(2'd3, 32'h1);
    rd("col_cap", 0, 2'd3, 32'h3);
    chk("col_irq", 32'(irq_a), 32'd1);
    wr(2'd3, 32'h3);
    rd("col_clr_cap", 0, 2'd3, 32'h0);
    chk("col_clr_irq", 32'(irq_a), 32'd0);

    // Masking and ignored writes on the any-edge instance.
    wr(2'd2, 32'h0);
    pins_b[2] = 1'b1;
    tick(5);
    rd("mask_cap_b", 1, 2'd3, 32'h4);
    chk("mask_irq_b0", 32'(irq_b), 32'd0);
    wr(2'd2, 32'h4);
    chk("mask_irq_b1", 32'(irq_b), 32'd1);
    pins_b[2] = 1'b0;
    tick(5);
    rd("mask_fall_cap_b", 1, 2'd3, 32'h4);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd("ign_data_a", 0, 2'd0, 32'hD);
    rd("ign_rsvd_a", 0, 2'd1, 32'h0);
    rd("ign_mask_b", 1, 2'd2, 32'h4);
    rd("ign_cap_b", 1, 2'd3, 32'h4);

    // Reset in the middle of a debounce with EDGECAP=0x5.
    pins_a[0] = 1'b0;
    pins_a[2] = 1'b0;
    tick(10);
    pins_a[0] = 1'b1;
    pins_a[2] = 1'b1;
    tick(10);
    rd("mid_cap_a", 0, 2'd3, 32'h5);
    chk("mid_irq_a", 32'(irq_a), 32'd1);
    pins_a[3] = 1'b0;
    repeat (4) cyc();
    reset_n = 1'b0;
    rd("rst_data_a", 0, 2'd0, 32'hF);
    rd("rst_mask_a", 0, 2'd2, 32'h0);
    rd("rst_cap_a", 0, 2'd3, 32'h0);
    rd("rst_cap_b", 1, 2'd3, 32'h0);
    chk("rst_irq_a", 32'(irq_a), 32'd0);
    chk("rst_irq_b", 32'(irq_b), 32'd0);
    tick(2);
    reset_n = 1'b1;
    cyc();
    repeat (4) cyc();
    rd("rel_r4_data", 0, 2'd0, 32'hF);
    cyc();
    rd("rel_r5_data", 0, 2'd0, 32'h5);
    tick(10);
    rd("rel_cap_a", 0, 2'd3, 32'h0);

    tick(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
